// File: rtl/icache_dual_fetch.sv
// Dual-slot instruction cache: registered lookup of pc and pc+4, single refill FSM.
// Optional pair register-dependency check enabled by defining ICACHE_PAIR_HAZARD_EN.
module icache_dual_fetch #(
  parameter int unsigned WAYS        = 2,
  parameter int unsigned SETS        = 64,
  parameter int unsigned BLOCK_BYTES = 64,
  parameter int unsigned ADDR_W      = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  output logic [31:0]       instr1,
  output logic [31:0]       instr2,
  output logic              valid1,
  output logic              valid2,
  output logic              pc8,
  output logic              stall,
  output logic              refill_req,
  input  logic              refill_ack,
  output logic [ADDR_W-1:0] refill_addr,
  input  logic              refill_beat_valid,
  input  logic [63:0]       refill_beat_data
);

  localparam int unsigned Beats = BLOCK_BYTES / 8;
  localparam int unsigned BeatW = $clog2(Beats);
  localparam int unsigned SetW  = $clog2(SETS);
  localparam int unsigned OffW  = 3 + BeatW;
  localparam int unsigned TagW  = ADDR_W - OffW - SetW;
  localparam int unsigned Lvls  = $clog2(WAYS);
  localparam int unsigned WayW  = (WAYS > 1) ? Lvls : 1;
  localparam int unsigned LruW  = (WAYS > 1) ? WAYS - 1 : 1;

  typedef enum logic [1:0] {StIdle, StReq, StFill} state_e;

  logic [63:0]     data_mem [WAYS][SETS][Beats];
  logic [TagW-1:0] tag_mem  [WAYS][SETS];

  state_e            state_q, state_d;
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   valid_d [SETS];
  logic [LruW-1:0]   lru_q [SETS];
  logic [LruW-1:0]   lru_d [SETS];
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [WayW-1:0]   victim_q, victim_d, victim_n;
  logic [BeatW-1:0]  beat_q, beat_d;
  logic              flushed_q, flushed_d;
  logic              v1_q, v1_d, v2_q, v2_d;
  logic [31:0]       i1_q, i1_d, i2_q, i2_d;
  logic              fill_we, tag_we, hazard;

  logic [ADDR_W-1:0] slot_addr [2];
  logic [SetW-1:0]   slot_set  [2];
  logic [TagW-1:0]   slot_tag  [2];
  logic [BeatW-1:0]  slot_beat [2];
  logic [WayW-1:0]   slot_way  [2];
  logic [31:0]       slot_word [2];
  logic [1:0]        slot_hit;
  logic [SetW-1:0]   fill_set;
  logic [TagW-1:0]   fill_tag;
  logic              unused_bits;

  assign slot_addr[0] = pc;
  assign slot_addr[1] = pc + ADDR_W'(4);
  assign fill_set     = raddr_q[OffW +: SetW];
  assign fill_tag     = raddr_q[ADDR_W-1 -: TagW];
  assign unused_bits  = ^{pc[1:0], slot_addr[1][1:0], raddr_q[OffW-1:0]};

  // Tree PLRU: node bit 0 means the replacement candidate lies in the left subtree.
  function automatic logic [LruW-1:0] plru_touch(logic [LruW-1:0] t, logic [WayW-1:0] way);
    logic [LruW-1:0] r;
    int unsigned w;
    r = t;
    w = 32'(way);
    for (int unsigned d = 0; d < Lvls; d++) begin
      for (int unsigned i = 0; i < LruW; i++) begin
        if (i == (32'd1 << d) - 1 + (w >> (Lvls - d))) r[i] = ((w >> (Lvls - 1 - d)) & 1) == 0;
      end
    end
    return r;
  endfunction

  function automatic logic [WayW-1:0] plru_victim(logic [LruW-1:0] t);
    int unsigned p;
    logic b;
    p = 0;
    for (int unsigned d = 0; d < Lvls; d++) begin
      b = 1'b0;
      for (int unsigned i = 0; i < LruW; i++) begin
        if (i == (32'd1 << d) - 1 + p) b = t[i];
      end
      p = 2 * p + 32'(b);
    end
    return WayW'(p);
  endfunction

  function automatic logic ends_pair(logic [31:0] ins);
    return ins[6:0] inside {7'h00, 7'h63, 7'h67, 7'h6F, 7'h73};
  endfunction

  for (genvar s = 0; s < 2; s++) begin : g_slot
    logic [63:0] beat_word;
    assign slot_set[s]  = slot_addr[s][OffW +: SetW];
    assign slot_tag[s]  = slot_addr[s][ADDR_W-1 -: TagW];
    assign slot_beat[s] = slot_addr[s][3 +: BeatW];
    always_comb begin
      slot_hit[s] = 1'b0;
      slot_way[s] = '0;
      for (int w = 0; w < WAYS; w++) begin
        if (valid_q[slot_set[s]][w] && tag_mem[w][slot_set[s]] == slot_tag[s]) begin
          slot_hit[s] = 1'b1;
          slot_way[s] = WayW'(w);
        end
      end
    end
    assign beat_word    = data_mem[slot_way[s]][slot_set[s]][slot_beat[s]];
    assign slot_word[s] = slot_addr[s][2] ? beat_word[63:32] : beat_word[31:0];
  end

  always_comb begin
    victim_n = plru_victim(lru_q[slot_set[0]]);
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[slot_set[0]][w]) victim_n = WayW'(w);
    end
  end

`ifdef ICACHE_PAIR_HAZARD_EN
  logic [4:0] hz_rd;
  logic       hz_wr, hz_r1, hz_r12;
  always_comb begin
    hz_rd  = slot_word[0][11:7];
    hz_wr  = slot_word[0][6:0] inside {7'h03, 7'h13, 7'h1B, 7'h17, 7'h37, 7'h33, 7'h3B};
    hz_r1  = slot_word[1][6:0] inside {7'h03, 7'h13, 7'h1B, 7'h67};
    hz_r12 = slot_word[1][6:0] inside {7'h23, 7'h33, 7'h3B, 7'h63};
    hazard = hz_wr && (hz_rd != 5'd0) &&
             (((hz_r1 || hz_r12) && hz_rd == slot_word[1][19:15]) ||
              (hz_r12 && hz_rd == slot_word[1][24:20]));
  end
`else
  assign hazard = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    lru_d     = lru_q;
    raddr_d   = raddr_q;
    victim_d  = victim_q;
    beat_d    = beat_q;
    flushed_d = flushed_q;
    v1_d      = 1'b0;
    v2_d      = 1'b0;
    i1_d      = i1_q;
    i2_d      = i2_q;
    fill_we   = 1'b0;
    tag_we    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fetch_en && !flush) begin
          if (slot_hit[0]) begin
            v1_d = 1'b1;
            i1_d = slot_word[0];
            i2_d = slot_word[1];
            v2_d = slot_hit[1] && !ends_pair(slot_word[0]) && !hazard;
            lru_d[slot_set[0]] = plru_touch(lru_d[slot_set[0]], slot_way[0]);
            if (slot_hit[1]) lru_d[slot_set[1]] = plru_touch(lru_d[slot_set[1]], slot_way[1]);
          end else begin
            state_d   = StReq;
            raddr_d   = pc & ~ADDR_W'(BLOCK_BYTES - 1);
            victim_d  = victim_n;
            beat_d    = '0;
            flushed_d = 1'b0;
          end
        end
      end
      StReq: if (refill_ack) state_d = StFill;
      StFill: begin
        if (refill_beat_valid) begin
          fill_we = 1'b1;
          beat_d  = beat_q + 1'b1;
          if (beat_q == BeatW'(Beats - 1)) begin
            state_d = StIdle;
            tag_we  = 1'b1;
            if (!flushed_q) begin
              valid_d[fill_set][victim_q] = 1'b1;
              lru_d[fill_set] = plru_touch(lru_q[fill_set], victim_q);
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // A flush landing mid-refill lets the fill finish but never validates the line.
    if (flush) begin
      for (int s = 0; s < SETS; s++) valid_d[s] = '0;
      if (state_q != StIdle) flushed_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      valid_q   <= '{default: '0};
      lru_q     <= '{default: '0};
      raddr_q   <= '0;
      victim_q  <= '0;
      beat_q    <= '0;
      flushed_q <= 1'b0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      i1_q      <= '0;
      i2_q      <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      lru_q     <= lru_d;
      raddr_q   <= raddr_d;
      victim_q  <= victim_d;
      beat_q    <= beat_d;
      flushed_q <= flushed_d;
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      i1_q      <= i1_d;
      i2_q      <= i2_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) data_mem[victim_q][fill_set][beat_q] <= refill_beat_data;
    if (tag_we) tag_mem[victim_q][fill_set] <= fill_tag;
  end

  assign stall       = state_q != StIdle;
  assign refill_req  = state_q == StReq;
  assign refill_addr = raddr_q;
  assign valid1      = v1_q & ~flush;
  assign valid2      = v2_q & ~flush;
  assign pc8         = valid2;
  assign instr1      = i1_q;
  assign instr2      = i2_q;

endmodule

// File: tb/tb_icache_dual_fetch.sv
// Randomized bench for icache_dual_fetch: line-level cache model feeds an expectation queue
// that an independent monitor drains whenever the DUT accepts a fetch.
module tb_icache_dual_fetch;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic [63:0] pc = '0;
  logic        flush = 1'b0;
  logic [31:0] instr1, instr2;
  logic        valid1, valid2, pc8, stall, refill_req;
  logic        refill_ack = 1'b0;
  logic [63:0] refill_addr;
  logic        refill_beat_valid = 1'b0;
  logic [63:0] refill_beat_data = '0;

  icache_dual_fetch dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .fetch_en          (fetch_en),
    .pc                (pc),
    .flush             (flush),
    .instr1            (instr1),
    .instr2            (instr2),
    .valid1            (valid1),
    .valid2            (valid2),
    .pc8               (pc8),
    .stall             (stall),
    .refill_req        (refill_req),
    .refill_ack        (refill_ack),
    .refill_addr       (refill_addr),
    .refill_beat_valid (refill_beat_valid),
    .refill_beat_data  (refill_beat_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v1;
    logic        v2;
    logic        st;
    logic [31:0] i1;
    logic [31:0] i2;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] ovr [logic [63:0]];

  // Reference cache: 64 sets x 2 ways of line addresses; with two ways PLRU is exact LRU.
  bit          mv    [64][2];
  logic [63:0] mline [64][2];
  int          mru   [64];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic [31:0] word(input logic [63:0] a);
    if (ovr.exists(a)) return ovr[a];
    return (a[31:0] * 32'h9E37_79B1) ^ 32'h1234_5673;
  endfunction

  function automatic bit is_stop(input logic [31:0] ins);
    return ins[6:0] inside {7'h00, 7'h63, 7'h67, 7'h6F, 7'h73};
  endfunction

  function automatic bit pair_hazard(input logic [31:0] a, input logic [31:0] b);
`ifdef ICACHE_PAIR_HAZARD_EN
    bit writes, use1, use2;
    writes = a[6:0] inside {7'h03, 7'h13, 7'h1B, 7'h17, 7'h37, 7'h33, 7'h3B} && a[11:7] != 0;
    use1   = b[6:0] inside {7'h03, 7'h13, 7'h1B, 7'h67, 7'h23, 7'h33, 7'h3B, 7'h63};
    use2   = b[6:0] inside {7'h23, 7'h33, 7'h3B, 7'h63};
    return writes && ((use1 && a[11:7] == b[19:15]) || (use2 && a[11:7] == b[24:20]));
`else
    return (a & b & 32'h0) != 0;
`endif
  endfunction

  task automatic lookup(input logic [63:0] a, output bit hit, output int way);
    int s;
    s = int'(a[11:6]);
    hit = 0;
    way = 0;
    for (int w = 0; w < 2; w++) begin
      if (mv[s][w] && mline[s][w] == (a >> 6)) begin
        hit = 1;
        way = w;
      end
    end
  endtask

  task automatic junk();
    fetch_en = 1'($urandom_range(0, 1));
    pc = {$urandom, $urandom};
  endtask

  task automatic refill(input logic [63:0] a, input int vic, input bit fl);
    logic [63:0] base;
    int s, n;
    base = {a[63:6], 6'b0};
    s = int'(a[11:6]);
    @(negedge clk);
    junk();
    n = 0;
    while (!refill_req && n < 20) begin
      @(negedge clk);
      junk();
      n++;
    end
    chk("refill_req_seen", 64'(refill_req), 64'd1);
    chk("refill_addr", refill_addr, base);
    repeat ($urandom_range(0, 2)) begin
      refill_beat_valid = 1'($urandom_range(0, 1));
      refill_beat_data = {$urandom, $urandom};
      @(negedge clk);
      junk();
      chk("refill_req_hold", 64'(refill_req), 64'd1);
      chk("refill_addr_hold", refill_addr, base);
    end
    refill_ack = 1'b1;
    refill_beat_valid = 1'b1;
    refill_beat_data = {$urandom, $urandom};
    @(negedge clk);
    refill_ack = 1'b0;
    refill_beat_valid = 1'b0;
    junk();
    for (int b = 0; b < 8; b++) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        junk();
      end
      refill_beat_valid = 1'b1;
      refill_beat_data = {word(base + 64'(8 * b + 4)), word(base + 64'(8 * b))};
      flush = fl && (b == 3);
      @(negedge clk);
      refill_beat_valid = 1'b0;
      flush = 1'b0;
      if (b < 7) begin
        junk();
        chk("stall_during_fill", 64'(stall), 64'd1);
      end
    end
    fetch_en = 1'b0;
    chk("stall_after_last_beat", 64'(stall), 64'd0);
    chk("refill_req_after_fill", 64'(refill_req), 64'd0);
    if (fl) begin
      mv = '{default: 0};
    end else begin
      mv[s][vic] = 1;
      mline[s][vic] = a >> 6;
      mru[s] = vic;
    end
  endtask

  task automatic do_fetch(input logic [63:0] a, input bit fl_mid);
    exp_t e;
    bit h1, h2;
    int w1, w2, s;
    @(negedge clk);
    fetch_en = 1'b1;
    pc = a;
    s = int'(a[11:6]);
    lookup(a, h1, w1);
    e.i1 = word(a);
    e.i2 = word(a + 64'd4);
    if (h1) begin
      lookup(a + 64'd4, h2, w2);
      e.v1 = 1;
      e.v2 = h2 && !is_stop(e.i1) && !pair_hazard(e.i1, e.i2);
      e.st = 0;
      mru[s] = w1;
      if (h2) mru[int'(((a + 64'd4) >> 6) & 64'h3F)] = w2;
      exp_q.push_back(e);
    end else begin
      int vic;
      e.v1 = 0;
      e.v2 = 0;
      e.st = 1;
      exp_q.push_back(e);
      vic = !mv[s][0] ? 0 : (!mv[s][1] ? 1 : 1 - mru[s]);
      refill(a, vic, fl_mid);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    fetch_en = 1'b0;
  endtask

  task automatic flush_idle();
    idle();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    mv = '{default: 0};
  endtask

  logic acc_q;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) acc_q <= 1'b0;
    else acc_q <= fetch_en && !stall && !flush;
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (acc_q) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_accept: got valid1=%0b stall=%0b expected no fetch accepted",
                   valid1, stall);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("valid1", 64'(valid1), 64'(e.v1));
          chk("valid2", 64'(valid2), 64'(e.v2));
          chk("pc8", 64'(pc8), 64'(e.v2));
          chk("stall", 64'(stall), 64'(e.st));
          chk("refill_req", 64'(refill_req), 64'(e.st));
          if (e.v1) chk("instr1", 64'(instr1), 64'(e.i1));
          if (e.v2) chk("instr2", 64'(instr2), 64'(e.i2));
        end
      end else begin
        chk("idle_valid1", 64'(valid1), 64'd0);
        chk("idle_pc8", 64'(pc8), 64'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] a;
    int r;
    ovr[64'h1000] = 32'h0000_0013;
    ovr[64'h1004] = 32'h0000_0013;
    ovr[64'h1008] = 32'h0000_006F;
    ovr[64'h100C] = 32'h0000_0013;
    ovr[64'h1010] = 32'h0010_0293;  // addi x5,x0,1
    ovr[64'h1014] = 32'h0012_8333;  // add x6,x5,x1
    ovr[64'h103C] = 32'h0000_0013;
    mv = '{default: 0};
    mru = '{default: 0};

    #12;
    chk("rst_valid1", 64'(valid1), 64'd0);
    chk("rst_valid2", 64'(valid2), 64'd0);
    chk("rst_pc8", 64'(pc8), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_refill_req", 64'(refill_req), 64'd0);
    chk("rst_refill_addr", refill_addr, 64'd0);
    chk("rst_instr1", 64'(instr1), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    do_fetch(64'h1000, 0);
    do_fetch(64'h1000, 0);
    do_fetch(64'h103C, 0);
    do_fetch(64'h1008, 0);
    do_fetch(64'h1010, 0);
    do_fetch(64'h2000, 0);
    do_fetch(64'h1000, 0);
    do_fetch(64'h3000, 0);
    do_fetch(64'h1000, 0);
    do_fetch(64'h2000, 0);
    flush_idle();
    do_fetch(64'h5000, 1);
    do_fetch(64'h5000, 0);
    do_fetch(64'h5004, 0);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 6) begin
        flush_idle();
      end else if (r < 20) begin
        idle();
      end else begin
        a = (64'($urandom_range(1, 4)) << 12) | (64'($urandom_range(0, 3)) << 6) |
            (64'($urandom_range(0, 15)) << 2);
        do_fetch(a, $urandom_range(0, 99) < 15);
      end
    end

    repeat (3) idle();
    chk("exp_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icache_dual_fetch.md
ICACHE_DUAL_FETCH -- requirements
Module: icache_dual_fetch

Interface
REQ-001 SHALL have parameter WAYS, default 2, ways per set; power of two, 1..8.
REQ-002 SHALL have parameter SETS, default 64, sets; power of two.
REQ-003 SHALL have parameter BLOCK_BYTES, default 64, line size; power of two, >=16.
REQ-004 SHALL have parameter ADDR_W, default 64, fetch address width.
REQ-005 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-006 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have port fetch_en  in  1  lookup request this cycle.
REQ-008 SHALL have port pc  in  ADDR_W  slot-1 address; slot 2 is pc+4.
REQ-009 SHALL have port flush  in  1  invalidate all lines.
REQ-010 SHALL have port instr1, instr2  out  32 each  fetched instructions.
REQ-011 SHALL have port valid1, valid2  out  1 each  slot qualifiers.
REQ-012 SHALL have port pc8  out  1  1: advance pc by 8, 0: by 4.
REQ-013 SHALL have port stall  out  1  miss in progress, hold pc.
REQ-014 SHALL have port refill_req / refill_ack  out/in  1 each  refill request handshake.
REQ-015 SHALL have port refill_addr  out  ADDR_W  block-aligned miss address.
REQ-016 SHALL have port refill_beat_valid / refill_beat_data  in  1 / 64  refill beats, 8 bytes each.

Function
REQ-017 Lookup SHALL be registered: outputs reflect the pc sampled at the fetch_en edge, one cycle later; no fetch_en -> valid1=valid2=0, pc8=0.
REQ-018 Address split SHALL be byte offset 3 bits, beat index log2(BLOCK_BYTES/8), set index log2(SETS), tag = remainder; pc[2] selects upper/lower word of the 64-bit beat.
REQ-019 Hit in any way with valid set and tag match SHALL give valid1=1; multiple matches SHALL not occur.
REQ-020 Slot-1 miss SHALL set valid1=valid2=0, stall=1, and FSM IDLE->REQ.
REQ-021 FSM states SHALL be IDLE, REQ, FILL; REQ holds refill_req=1 and refill_addr stable until refill_ack; REQ->FILL on ack.
REQ-022 FILL SHALL write each beat into the victim way at incrementing beat index from 0; after BLOCK_BYTES/8 beats it SHALL set valid+tag, mark way most-recent, and return to IDLE.
REQ-023 stall SHALL drop the cycle after the last beat; fetch_en while stall=1 SHALL be ignored.
REQ-024 Victim SHALL be the first invalid way, else tree pseudo-LRU way; WAYS=1 always way 0.
REQ-025 Every slot hit SHALL update pseudo-LRU of its set; simultaneous slot-1 and slot-2 update to the same set SHALL apply slot 2 last.
REQ-026 Slot 2 SHALL be valid only if slot 1 valid, slot 2 hits (no refill for slot-2 miss, incl. line crossing), and instr1[6:0] not in {0x00,0x63,0x67,0x6F,0x73}.
REQ-027 pc8 SHALL equal valid2.
REQ-028 flush SHALL clear all valid bits in one cycle and force valid1=valid2=0 that cycle; flush during REQ/FILL SHALL complete the transaction without validating the line.
REQ-029 refill_beat_valid outside FILL SHALL be ignored.

Reset
REQ-030 reset_n low SHALL asynchronously clear all valid bits, LRU state, beat counter, FSM to IDLE, and all outputs to 0; reset mid-FILL abandons the fill.
REQ-031 Data/tag arrays SHALL not require reset.

Configuration
REQ-032 With ICACHE_PAIR_HAZARD_EN defined, slot 2 SHALL additionally be dropped (valid2=0, pc8=0) when instr1 opcode in {0x03,0x13,0x1B,0x17,0x37,0x33,0x3B}, rd!=0 and rd equals instr2 rs1 (instr2 opcode 0x03,0x13,0x1B,0x67) or rs1/rs2 (0x23,0x33,0x3B,0x63).
REQ-033 Without ICACHE_PAIR_HAZARD_EN, no register-dependency check SHALL be made.

Verification
REQ-034 Reset, fetch pc=0x1000 -> stall=1 next cycle, refill_req=1, refill_addr=0x1000; ack + 8 beats -> stall=0, refetch gives valid1=valid2=1, pc8=1.
REQ-035 pc=0x103C (last word of line), next line absent -> valid1=1, valid2=0, pc8=0, no refill_req.
REQ-036 instr1=0x0000006F (jal) at hit -> valid2=0, pc8=0.
REQ-037 WAYS=2: fill tags A,B in set 0, hit A, miss C -> C replaces B; hit A still valid.
REQ-038 HAZARD_EN: instr1=addi x5,x0,1, instr2=add x6,x5,x1 -> valid2=0, pc8=0; macro off -> valid2=1.
REQ-039 flush asserted at beat 3 of 8 -> fill completes, refetch same pc misses again.
